ppu_vram_arbiter: RTL

Two-channel PPU VRAM access unit. It arbitrates between the render fetch channel and the CPU data-port ($2007) channel, and translates 16-bit PPU addresses into the physical VRAM map. Translation covers the $4000 fold, nametable mirroring under a runtime mode, the $3000 fold, and palette aliasing. It then drives a single-port memory with configurable read latency and returns data per channel with a valid pulse.

---
 rtl/ppu_vram_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ppu_vram_arbiter.sv
// Two-channel PPU VRAM arbiter: render/CPU fairness, PPU-to-physical address translation, fixed-latency memory port.
// Optional CPU $2007 read buffer is enabled by defining PPU_READ_BUFFER_EN.
module ppu_vram_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int DATA_W  = 8,
  parameter int PHYS_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mirror_mode,
  input  logic              rnd_req,
  input  logic [15:0]       rnd_addr,
  input  logic              cpu_req,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              rnd_ack,
  output logic              cpu_ack,
  output logic              rnd_rvalid,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] rnd_rdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [PHYS_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     r_state;
  logic [2:0] r_lat_cnt;
  logic       r_cpu_prio;
  logic       r_chan;
  logic       r_we;
`ifdef PPU_READ_BUFFER_EN
  logic              r_pal;
  logic [DATA_W-1:0] r_buf;
`endif

  logic        w_grant_cpu;
  logic [13:0] w_a;
  logic [13:0] w_phys;
  logic [3:0]  w_unused_hi;

  // PPU address (already folded to 14 bits) to physical VRAM address
  function automatic logic [13:0] f_translate(input logic [13:0] a, input logic [1:0] mode);
    logic       bank;
    logic [4:0] p;
    bank = 1'b0;
    p    = a[4:0];
    if (a < 14'h2000) return a;
    if (a < 14'h3F00) begin
      case (mode)
        2'd0:    bank = a[11];
        2'd1:    bank = a[10];
        2'd2:    bank = 1'b0;
        default: bank = 1'b1;
      endcase
      return {1'b1, 2'b00, bank, a[9:0]};
    end
    if (p[1:0] == 2'b00) p[4] = 1'b0;
    return {9'h1F8, p};
  endfunction

  // CPU only wins a contested grant after it lost the previous one
  assign w_grant_cpu = cpu_req && (!rnd_req || r_cpu_prio);
  assign w_a         = w_grant_cpu ? cpu_addr[13:0] : rnd_addr[13:0];
  assign w_phys      = f_translate(w_a, mirror_mode);
  assign w_unused_hi = {rnd_addr[15:14], cpu_addr[15:14]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lat_cnt  <= 3'd0;
      r_cpu_prio <= 1'b0;
      r_chan     <= 1'b0;
      r_we       <= 1'b0;
      rnd_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      rnd_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      rnd_rdata  <= '0;
      cpu_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef PPU_READ_BUFFER_EN
      r_pal      <= 1'b0;
      r_buf      <= '0;
`endif
    end else begin
      rnd_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      rnd_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rnd_req || cpu_req) begin
            r_state    <= ACCESS;
            r_chan     <= w_grant_cpu;
            r_we       <= w_grant_cpu && cpu_we;
            r_cpu_prio <= !w_grant_cpu && cpu_req;
            rnd_ack    <= !w_grant_cpu;
            cpu_ack    <= w_grant_cpu;
            mem_en     <= 1'b1;
            mem_we     <= w_grant_cpu && cpu_we;
            mem_addr   <= PHYS_W'(w_phys);
            mem_wdata  <= cpu_wdata;
`ifdef PPU_READ_BUFFER_EN
            r_pal      <= (w_a >= 14'h3F00);
`endif
          end
        end
        ACCESS: begin
          r_state   <= WAIT;
          r_lat_cnt <= 3'd1;
        end
        WAIT: begin
          if (r_lat_cnt == 3'(MEM_LAT)) begin
            r_state   <= RESP;
            r_lat_cnt <= 3'd0;
            if (r_chan) begin
              cpu_rvalid <= 1'b1;
              if (!r_we) begin
`ifdef PPU_READ_BUFFER_EN
                if (r_pal) begin
                  cpu_rdata <= mem_rdata;
                end else begin
                  cpu_rdata <= r_buf;
                  r_buf     <= mem_rdata;
                end
`else
                cpu_rdata <= mem_rdata;
`endif
              end
            end else begin
              rnd_rvalid <= 1'b1;
              rnd_rdata  <= mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
